jt1943_rom_arbiter: RTL and testbench
=====================================

JT1943_ROM_ARBITER -- requirements
Module: jt1943_rom_arbiter

Interface
REQ-001 Parameter DATA_LAT, default 4: clk cycles from sdram_re toggle to valid data_read (range 1..15).
REQ-002 Parameter REF_PERIOD, default 1536: clk cycles between autorefresh slots.
REQ-003 Parameter REF_LEN, default 8: clk cycles autorefresh is held high per slot.
REQ-004 clk  in  1  SDRAM-domain clock (clk_rom in the game); single clock for the whole block.
REQ-005 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-006 downloading  in  1  ROM download in progress; no grants while high.
REQ-007 loop_rst  in  1  SDRAM init loop active; no grants while high.
REQ-008 req  in  4  per-port read request level; port 0 main CPU, 1 sound CPU, 2 char/scroll, 3 objects.
REQ-009 addr0..addr3  in  22 each  per-port word address; held stable while req high.
REQ-010 ok  out  4  one-cycle per-port completion strobe.
REQ-011 dout  out  32  captured SDRAM word, valid in the ok cycle and held until the next capture.
REQ-012 sdram_re  out  1  read request toggle to SDRAM controller (both edges significant).
REQ-013 sdram_addr  out  22  address presented with sdram_re.
REQ-014 data_read  in  32  SDRAM read data.
REQ-015 autorefresh  out  1  SDRAM autorefresh request level.

Function
REQ-016 States IDLE, WAIT, REFRESH; reset state IDLE.
REQ-017 Reset values: ok=0, dout=0, sdram_re=0, sdram_addr=0, autorefresh=0, round-robin pointer=0, refresh counter=0, refresh pending=0.
REQ-018 Hold condition = downloading | loop_rst; while high, IDLE makes no transition, ok=0, autorefresh=0, sdram_re does not toggle; refresh counter cleared and held.
REQ-019 Hold asserted in WAIT: transaction completes normally (ok still issued); hold asserted in REFRESH: autorefresh drops next cycle, state to IDLE, pending cleared.
REQ-020 Refresh counter increments every non-hold cycle; at REF_PERIOD-1 it wraps to 0 and sets pending; pending already set is not double-counted.
REQ-021 IDLE with pending set: refresh wins over all req; next cycle autorefresh=1, state REFRESH for exactly REF_LEN cycles, then autorefresh=0, pending cleared, IDLE.
REQ-022 IDLE, no pending, any req bit high: select first requesting port scanning from pointer upward, modulo 4.
REQ-023 On selection edge: sdram_addr<=addr of winner, sdram_re<=~sdram_re, latency counter<=DATA_LAT, pointer<=winner+1 mod 4, state WAIT.
REQ-024 WAIT decrements counter each cycle; on the edge where it reaches 0: dout<=data_read, ok[winner]<=1, state IDLE.
REQ-025 Latency: ok visible exactly DATA_LAT+2 cycles after the first rising edge sampling req high in IDLE with no competitor or refresh.
REQ-026 ok is one-hot or zero, always exactly one cycle wide.
REQ-027 Requester may drop req in the ok cycle; a req still high in the cycle after ok is a new request for the current addr.
REQ-028 IDLE spends at least one cycle between consecutive transactions (ok cycle counts as that IDLE cycle; new selection may occur on that same edge).
REQ-029 req bits of non-selected ports are ignored during WAIT/REFRESH; no request is lost, only delayed.
REQ-030 Worst-case wait for any requesting port: 3 other transactions plus one refresh slot.

Reset
REQ-031 rst_n low forces all REQ-017 values immediately, independent of clk, aborting any transaction without issuing ok.
REQ-032 After rst_n release, first possible sdram_re toggle occurs on the second rising edge.

Verification
REQ-033 Single request: req=0001, addr0=22'h01234, DATA_LAT=4 -> sdram_addr=22'h01234, sdram_re toggles once, ok=0001 six cycles later, dout=data_read sampled at that edge.
REQ-034 Contention: req=1111 held -> grant order 0,1,2,3,0 with ok strobes spaced DATA_LAT+2 cycles apart, never two bits set.
REQ-035 Refresh: REF_PERIOD=16, REF_LEN=8, req=0100 continuous -> autorefresh high 8 cycles once per 16 counted cycles, taken only from IDLE, no ok during it.
REQ-036 Download: downloading=1 with req=1111 for 100 cycles -> sdram_re constant, ok=0, autorefresh=0; after release, port at pointer served first.
REQ-037 Reset mid-WAIT: rst_n low 2 cycles after grant -> ok never asserted for that grant, all outputs zero, pointer 0 after release.
REQ-038 Pointer wrap: serve port 3 alone, then req=1001 -> port 0 granted next.

Source files
------------

// File: rtl/jt1943_rom_arbiter.sv
// jt1943_rom_arbiter
//   Shares one SDRAM read channel between four ROM clients (main CPU, sound
//   CPU, char/scroll, objects) with round-robin arbitration, and inserts
//   periodic autorefresh slots. Everything runs on the SDRAM clock.
//
// Parameters
//   DATA_LAT    cycles from an sdram_re toggle to valid data_read (1..15)
//   REF_PERIOD  cycles between autorefresh slots
//   REF_LEN     cycles autorefresh is held high per slot
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   downloading         ROM download in progress: no new grants
//   loop_rst            SDRAM init loop active: no new grants
//   req[3:0]            per-port read request level
//   addr0..addr3        per-port word address, stable while req is high
//   ok[3:0]             one-cycle per-port completion strobe
//   dout[31:0]          captured SDRAM word, held until the next capture
//   sdram_re            read request toggle (both edges start a read)
//   sdram_addr[21:0]    address presented with sdram_re
//   data_read[31:0]     SDRAM read data
//   autorefresh         SDRAM autorefresh request level
module jt1943_rom_arbiter #(
  parameter int unsigned DATA_LAT   = 4,
  parameter int unsigned REF_PERIOD = 1536,
  parameter int unsigned REF_LEN    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic        loop_rst,
  input  logic [3:0]  req,
  input  logic [21:0] addr0,
  input  logic [21:0] addr1,
  input  logic [21:0] addr2,
  input  logic [21:0] addr3,
  output logic [3:0]  ok,
  output logic [31:0] dout,
  output logic        sdram_re,
  output logic [21:0] sdram_addr,
  input  logic [31:0] data_read,
  output logic        autorefresh
);

  localparam int unsigned RCW = (REF_PERIOD > 2) ? $clog2(REF_PERIOD) : 1;
  localparam int unsigned RLW = (REF_LEN > 2) ? $clog2(REF_LEN) : 1;
  localparam logic [RCW-1:0] REF_LAST = RCW'(REF_PERIOD - 1);
  localparam logic [RLW-1:0] LEN_LAST = RLW'(REF_LEN - 1);
  localparam logic [3:0]     LAT_LOAD = 4'(DATA_LAT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_REFRESH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      req_q;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      win_q, win_d;
  logic [3:0]      lat_q, lat_d;
  logic [RCW-1:0]  rcnt_q, rcnt_d;
  logic            pend_q, pend_d;
  logic [RLW-1:0]  rlen_q, rlen_d;
  logic [3:0]      ok_q, ok_d;
  logic [31:0]     dout_q, dout_d;
  logic            re_q, re_d;
  logic [21:0]     addr_q, addr_d;
  logic            ar_q, ar_d;

  logic            hold;
  logic [3:0]      elig;
  logic            sel_found;
  logic [1:0]      sel_port;
  logic [1:0]      scan;
  logic [21:0]     sel_addr;
  logic            pend_set;
  logic            pend_clr;

  assign hold = downloading | loop_rst;

  // Requests are sampled one cycle before arbitration. The port whose ok is
  // currently showing is masked because its registered request still
  // reflects the level from before it saw ok.
  assign elig = req_q & ~ok_q;

  always_comb begin
    sel_found = 1'b0;
    sel_port  = ptr_q;
    scan      = ptr_q;
    for (int unsigned i = 0; i < 4; i++) begin
      scan = ptr_q + 2'(i);
      if (!sel_found && elig[scan]) begin
        sel_found = 1'b1;
        sel_port  = scan;
      end
    end
  end

  always_comb begin
    case (sel_port)
      2'd0:    sel_addr = addr0;
      2'd1:    sel_addr = addr1;
      2'd2:    sel_addr = addr2;
      default: sel_addr = addr3;
    endcase
  end

  // Refresh interval counter: cleared while held, sets pending on wrap.
  always_comb begin
    rcnt_d   = rcnt_q;
    pend_set = 1'b0;
    if (hold) begin
      rcnt_d = '0;
    end else if (rcnt_q == REF_LAST) begin
      rcnt_d   = '0;
      pend_set = 1'b1;
    end else begin
      rcnt_d = rcnt_q + RCW'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    lat_d    = lat_q;
    rlen_d   = rlen_q;
    ok_d     = '0;
    dout_d   = dout_q;
    re_d     = re_q;
    addr_d   = addr_q;
    ar_d     = ar_q;
    pend_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!hold) begin
          if (pend_q) begin
            state_d = ST_REFRESH;
            ar_d    = 1'b1;
            rlen_d  = '0;
          end else if (sel_found) begin
            state_d = ST_WAIT;
            addr_d  = sel_addr;
            re_d    = ~re_q;
            lat_d   = LAT_LOAD;
            win_d   = sel_port;
            ptr_d   = sel_port + 2'd1;
          end
        end
      end
      ST_WAIT: begin
        // Capture happens on the edge after the counter has reached zero,
        // one cycle after data_read becomes valid.
        if (lat_q == 4'd0) begin
          state_d       = ST_IDLE;
          dout_d        = data_read;
          ok_d[win_q]   = 1'b1;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      ST_REFRESH: begin
        if (hold || rlen_q == LEN_LAST) begin
          state_d  = ST_IDLE;
          ar_d     = 1'b0;
          pend_clr = 1'b1;
        end else begin
          rlen_d = rlen_q + RLW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ar_d    = 1'b0;
      end
    endcase
  end

  assign pend_d = pend_set | (pend_q & ~pend_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      lat_q   <= '0;
      rcnt_q  <= '0;
      pend_q  <= 1'b0;
      rlen_q  <= '0;
      ok_q    <= '0;
      dout_q  <= '0;
      re_q    <= 1'b0;
      addr_q  <= '0;
      ar_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      lat_q   <= lat_d;
      rcnt_q  <= rcnt_d;
      pend_q  <= pend_d;
      rlen_q  <= rlen_d;
      ok_q    <= ok_d;
      dout_q  <= dout_d;
      re_q    <= re_d;
      addr_q  <= addr_d;
      ar_q    <= ar_d;
    end
  end

  assign ok          = ok_q;
  assign dout        = dout_q;
  assign sdram_re    = re_q;
  assign sdram_addr  = addr_q;
  assign autorefresh = ar_q;

endmodule

// File: tb/tb_jt1943_rom_arbiter.sv
// Testbench for jt1943_rom_arbiter: a default-parameter instance driven by
// directed sequences with a scoreboard, plus a short-refresh instance whose
// refresh slots are checked against the transaction stream.
module tb_jt1943_rom_arbiter;
  localparam int LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [21:0] a);
    return {a[9:0], a} ^ 32'hA5C3_0F96;
  endfunction

  // ---------------- main instance ----------------
  logic        rst_n = 1'b1;
  logic        downloading = 1'b0;
  logic        loop_rst = 1'b0;
  logic [3:0]  req = '0;
  logic [21:0] addr0 = '0, addr1 = '0, addr2 = '0, addr3 = '0;
  logic [3:0]  ok;
  logic [31:0] dout;
  logic        sdram_re;
  logic [21:0] sdram_addr;
  logic [31:0] data_read = '0;
  logic        autorefresh;

  jt1943_rom_arbiter #(.DATA_LAT(LAT)) u_main (
    .clk(clk), .rst_n(rst_n), .downloading(downloading), .loop_rst(loop_rst),
    .req(req), .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .ok(ok), .dout(dout), .sdram_re(sdram_re), .sdram_addr(sdram_addr),
    .data_read(data_read), .autorefresh(autorefresh)
  );

  typedef struct {
    logic [3:0]  okv;
    logic [21:0] addr;
    int          exp_cyc;
  } exp_t;
  exp_t sb[$];

  // SDRAM model plus output monitor
  logic        re_prev = 1'b0;
  int          lat_left = 0;
  logic [21:0] last_addr = '0;
  int          tog_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    if (sdram_re !== re_prev) begin
      re_prev   = sdram_re;
      tog_cnt++;
      last_addr = sdram_addr;
      data_read = 32'hDEAD_BEEF;
      lat_left  = LAT - 1;
      if (lat_left == 0) data_read = mem_word(sdram_addr);
    end else if (lat_left > 0) begin
      lat_left--;
      if (lat_left == 0) data_read = mem_word(last_addr);
    end
    if (ok !== 4'b0) begin
      chk("ok onehot", $onehot0(ok), 1);
      if (sb.size() == 0) begin
        chk("unexpected ok", ok, 0);
      end else begin
        e = sb.pop_front();
        chk("ok port", ok, e.okv);
        chk("dout", dout, mem_word(e.addr));
        chk("granted addr", last_addr, e.addr);
        if (e.exp_cyc >= 0) chk("ok latency", cyc, e.exp_cyc);
      end
    end
  end

  // ---------------- short-refresh instance ----------------
  logic        rst_nr = 1'b1;
  logic [3:0]  ok_r;
  logic [31:0] dout_r;
  logic        re_r;
  logic [21:0] addr_r;
  logic        ar_r;
  logic        ref_done = 1'b0;

  jt1943_rom_arbiter #(.DATA_LAT(LAT), .REF_PERIOD(16), .REF_LEN(8)) u_ref (
    .clk(clk), .rst_n(rst_nr), .downloading(1'b0), .loop_rst(1'b0),
    .req(4'b0100), .addr0(22'h0), .addr1(22'h0), .addr2(22'h2ABCD), .addr3(22'h0),
    .ok(ok_r), .dout(dout_r), .sdram_re(re_r), .sdram_addr(addr_r),
    .data_read(32'h0), .autorefresh(ar_r)
  );

  initial begin
    logic rp, arp, busy;
    int run, pulses, oks;
    rp = 1'b0; arp = 1'b0; busy = 1'b0; run = 0; pulses = 0; oks = 0;
    #2 rst_nr = 1'b0;
    repeat (3) @(negedge clk);
    rst_nr = 1'b1;
    repeat (400) begin
      @(negedge clk);
      if (re_r !== rp) begin
        rp = re_r;
        busy = 1'b1;
        chk("ref grant outside refresh", ar_r, 0);
      end
      if (ok_r !== 4'b0) begin
        busy = 1'b0;
        oks++;
        chk("ref ok port", ok_r, 4'b0100);
      end
      if (ar_r) begin
        run++;
        chk("ref no ok in refresh", ok_r, 0);
        if (!arp) begin
          pulses++;
          chk("ref taken from idle", busy, 0);
        end
      end else if (arp) begin
        chk("ref pulse width", run, 8);
        run = 0;
      end
      arp = ar_r;
    end
    chk("ref pulse count", (pulses >= 24 && pulses <= 25), 1);
    chk("ref port served", oks >= 10, 1);
    ref_done = 1'b1;
  end

  // ---------------- main stimulus ----------------
  int rem[4] = '{0, 0, 0, 0};

  task automatic step();
    @(negedge clk);
    for (int p = 0; p < 4; p++) begin
      if (ok[p] && rem[p] > 0) begin
        rem[p]--;
        if (rem[p] == 0) req[p] = 1'b0;
      end
    end
  endtask

  task automatic push(input logic [3:0] okv, input logic [21:0] a, input int ec);
    exp_t e;
    e.okv = okv; e.addr = a; e.exp_cyc = ec;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      step();
      n++;
    end
    chk("scoreboard drained", sb.size(), 0);
    repeat (3) step();
  endtask

  task automatic check_reset_outputs();
    chk("reset ok", ok, 0);
    chk("reset dout", dout, 0);
    chk("reset sdram_re", sdram_re, 0);
    chk("reset sdram_addr", sdram_addr, 0);
    chk("reset autorefresh", autorefresh, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  initial begin
    int c, t0, n;
    logic re_hold;

    // Single request held through reset; first toggle on second edge.
    #2 rst_n = 1'b0;
    req   = 4'b0001;
    addr0 = 22'h01234;
    rem   = '{1, 0, 0, 0};
    repeat (2) step();
    #1 check_reset_outputs();
    step();
    rst_n = 1'b1;
    c  = int'(cyc);
    t0 = tog_cnt;
    push(4'b0001, 22'h01234, c + LAT + 3);
    step();
    chk("no toggle on first edge", sdram_re, 0);
    step();
    chk("toggle on second edge", sdram_re, 1);
    chk("sdram_addr single", sdram_addr, 22'h01234);
    wait_done(40);
    chk("single toggle count", tog_cnt - t0, 1);

    // Contention: all ports, order 0,1,2,3,0.
    do_reset();
    c = int'(cyc);
    addr0 = 22'h00A00; addr1 = 22'h11B11; addr2 = 22'h22C22; addr3 = 22'h3FFFFF;
    req = 4'b1111;
    rem = '{2, 1, 1, 1};
    push(4'b0001, addr0, c + 7);
    push(4'b0010, addr1, c + 13);
    push(4'b0100, addr2, c + 19);
    push(4'b1000, addr3, c + 25);
    push(4'b0001, addr0, c + 31);
    wait_done(60);

    // Pointer wrap: port 3 alone, then ports 0 and 3 together.
    do_reset();
    c = int'(cyc);
    req = 4'b1000; rem = '{0, 0, 0, 1};
    push(4'b1000, addr3, c + 7);
    wait_done(30);
    c = int'(cyc);
    req = 4'b1001; rem = '{1, 0, 0, 1};
    push(4'b0001, addr0, c + 7);
    push(4'b1000, addr3, c + 13);
    wait_done(40);

    // Download / init-loop hold, with the pointer moved to port 2 first.
    c = int'(cyc);
    req = 4'b0010; rem = '{0, 1, 0, 0};
    push(4'b0010, addr1, c + 7);
    wait_done(30);
    downloading = 1'b1;
    req = 4'b1111; rem = '{1, 1, 1, 1};
    re_hold = sdram_re;
    for (int i = 0; i < 100; i++) begin
      step();
      chk("download sdram_re", sdram_re, re_hold);
      chk("download ok", ok, 0);
      chk("download autorefresh", autorefresh, 0);
    end
    downloading = 1'b0;
    loop_rst    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("loop_rst sdram_re", sdram_re, re_hold);
      chk("loop_rst ok", ok, 0);
    end
    push(4'b0100, addr2, -1);
    push(4'b1000, addr3, -1);
    push(4'b0001, addr0, -1);
    push(4'b0010, addr1, -1);
    loop_rst = 1'b0;
    wait_done(80);

    // Reset two cycles after a grant aborts it; pointer returns to 0.
    req = 4'b0100; rem = '{0, 0, 1, 0};
    step(); step();
    chk("mid-wait grant issued", sdram_addr, addr2);
    step(); step();
    rst_n = 1'b0;
    req   = '0;
    #1 check_reset_outputs();
    repeat (2) step();
    rst_n = 1'b1;
    c = int'(cyc);
    req = 4'b1010; rem = '{0, 1, 0, 1};
    push(4'b0010, addr1, c + 7);
    push(4'b1000, addr3, c + 13);
    wait_done(40);

    n = 0;
    while (!ref_done && n < 2000) begin
      step();
      n++;
    end
    chk("ref bench completed", ref_done, 1);
    chk("scoreboard empty at end", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
